key_stream_loader: RTL and testbench

KEY_STREAM_LOADER -- requirements
Module: key_stream_loader

---
 rtl/key_stream_loader_if.sv | 25 ++
 rtl/key_stream_loader.sv | 107 ++++++++++
 tb/tb_key_stream_loader.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_stream_loader_if.sv
// rtl/key_stream_loader_if.sv - key intake and key word stream handshake bundle
interface key_stream_loader_if #(
  parameter int KEY_WIDTH  = 256,
  parameter int WORD_WIDTH = 32
);
  logic                  key_valid;
  logic [KEY_WIDTH-1:0]  key_data;
  logic [7:0]            key_id;
  logic                  key_ready;
  logic                  out_valid;
  logic                  out_ready;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  out_last;
  logic [7:0]            out_key_id;

  modport master (
    output key_valid, key_data, key_id, out_ready,
    input  key_ready, out_valid, out_data, out_last, out_key_id
  );

  modport slave (
    input  key_valid, key_data, key_id, out_ready,
    output key_ready, out_valid, out_data, out_last, out_key_id
  );
endinterface

// File: rtl/key_stream_loader.sv
// rtl/key_stream_loader.sv - streams a wide key to the cipher engine word by word, LSW first
module key_stream_loader #(
  parameter int KEY_WIDTH  = 256,
  parameter int WORD_WIDTH = 32,
  parameter int STALL_MAX  = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  key_stream_loader_if.slave      bus,
  input  logic                    tamper_detect,
  input  logic                    err_clr,
  output logic                    done,
  output logic [1:0]              err
);
  localparam int NWORDS = KEY_WIDTH / WORD_WIDTH;
  localparam int CW     = $clog2(NWORDS);
  localparam int SW     = $clog2(STALL_MAX + 1);
  localparam logic [CW-1:0] LAST_IDX  = CW'(NWORDS - 1);
  localparam logic [SW-1:0] STALL_LIM = SW'(STALL_MAX - 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] WIPE = 2'd2;
  localparam logic [1:0] ERR  = 2'd3;

  logic [1:0]           state;
  logic [KEY_WIDTH-1:0] shadow;
  logic [CW-1:0]        word_cnt;
  logic [SW-1:0]        stall_cnt;
  logic [7:0]           key_id_q;
  logic [1:0]           err_q;
  logic                 ready_int;
  logic                 valid_int;
  logic                 accept;
  logic                 xfer;

  // Tamper gates the handshakes combinationally so a coinciding transfer never counts.
  assign ready_int = (state == IDLE) && !tamper_detect && (err_q == 2'b00);
  assign valid_int = (state == SEND) && !tamper_detect;
  assign accept    = bus.key_valid && ready_int;
  assign xfer      = valid_int && bus.out_ready;

  assign bus.key_ready  = ready_int;
  assign bus.out_valid  = valid_int;
  assign bus.out_data   = valid_int ? shadow[WORD_WIDTH-1:0] : '0;
  assign bus.out_last   = valid_int && (word_cnt == LAST_IDX);
  assign bus.out_key_id = key_id_q;
  assign done           = (state == WIPE);
  assign err            = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shadow    <= '0;
      word_cnt  <= '0;
      stall_cnt <= '0;
      key_id_q  <= 8'd0;
      err_q     <= 2'b00;
    end else if (tamper_detect) begin
      state     <= ERR;
      shadow    <= '0;
      key_id_q  <= 8'd0;
      err_q[1]  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shadow    <= bus.key_data;
            key_id_q  <= bus.key_id;
            word_cnt  <= '0;
            stall_cnt <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            shadow    <= shadow >> WORD_WIDTH;
            word_cnt  <= word_cnt + 1'b1;
            stall_cnt <= '0;
            if (word_cnt == LAST_IDX) begin
              state <= WIPE;
            end
          end else if (stall_cnt == STALL_LIM) begin
            shadow   <= '0;
            err_q[0] <= 1'b1;
            state    <= ERR;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
        end
        WIPE: begin
          shadow   <= '0;
          key_id_q <= 8'd0;
          word_cnt <= '0;
          state    <= IDLE;
        end
        ERR: begin
          if (err_clr) begin
            err_q <= 2'b00;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_key_stream_loader.sv
// tb/tb_key_stream_loader.sv - vector table plus word scoreboard bench for key_stream_loader
module tb_key_stream_loader;
  localparam int KW   = 256;
  localparam int WW   = 32;
  localparam int NW   = KW / WW;
  localparam int SMAX = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tamper_detect = 1'b0;
  logic       err_clr = 1'b0;
  logic       done;
  logic [1:0] err;
  int         rmode = 0;

  key_stream_loader_if #(.KEY_WIDTH(KW), .WORD_WIDTH(WW)) bus ();

  key_stream_loader #(.KEY_WIDTH(KW), .WORD_WIDTH(WW), .STALL_MAX(SMAX)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .tamper_detect(tamper_detect),
    .err_clr(err_clr),
    .done(done),
    .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WW-1:0] data;
    logic          last;
    logic [7:0]    id;
  } word_t;

  typedef struct {
    logic [KW-1:0] key;
    logic [7:0]    id;
    int            mode;
    logic [1:0]    exp_err;
    int            exp_done;
  } vec_t;

  word_t exp_q[$];
  int n_vec  = 0;
  int n_bad  = 0;
  int n_done = 0;

  function automatic void chk(input string nm, input logic [KW-1:0] act, input logic [KW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endfunction

  // Scoreboard: words pushed at key handshake, popped on each transfer.
  always @(negedge clk) begin
    if (!rst) begin
      if (done) n_done++;
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_valid", KW'(bus.out_valid), KW'(0));
        end else begin
          chk("out_data", KW'(bus.out_data), KW'(exp_q[0].data));
          chk("out_last", KW'(bus.out_last), KW'(exp_q[0].last));
          chk("out_key_id", KW'(bus.out_key_id), KW'(exp_q[0].id));
          if (bus.out_ready) void'(exp_q.pop_front());
        end
      end else begin
        chk("out_data_hidden", KW'(bus.out_data), KW'(0));
        chk("out_last_idle", KW'(bus.out_last), KW'(0));
      end
    end
  end

  // out_ready patterns: 0 always, 1 toggle, 2 one-in-three, other never.
  initial begin
    int ph = 0;
    bus.out_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      ph++;
      case (rmode)
        0:       bus.out_ready = 1'b1;
        1:       bus.out_ready = ~bus.out_ready;
        2:       bus.out_ready = (ph % 3 == 0);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  task automatic send_key(input logic [KW-1:0] k, input logic [7:0] id);
    int t = 0;
    word_t w;
    @(posedge clk);
    #1;
    bus.key_valid = 1'b1;
    bus.key_data  = k;
    bus.key_id    = id;
    @(negedge clk);
    while (!bus.key_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("key_accept", KW'(bus.key_ready), KW'(1));
    for (int i = 0; i < NW; i++) begin
      w.data = k[i*WW +: WW];
      w.last = (i == NW - 1);
      w.id   = id;
      exp_q.push_back(w);
    end
    @(posedge clk);
    #1;
    bus.key_valid = 1'b0;
  endtask

  task automatic run_key(input logic [KW-1:0] k, input logic [7:0] id, input int mode,
                         input logic [1:0] exp_err, input int exp_done);
    int cyc = 0;
    int d0;
    rmode = mode;
    d0 = n_done;
    send_key(k, id);
    @(negedge clk);
    cyc = 1;
    chk("first_word_latency", KW'(bus.out_valid), KW'(1));
    while (!done && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("done_seen", KW'(done), KW'(1));
    if (mode == 0) chk("stream_cycles", KW'(cyc), KW'(NW + 1));
    chk("queue_drained", KW'(exp_q.size()), KW'(0));
    @(negedge clk);
    chk("done_one_cycle", KW'(done), KW'(0));
    chk("key_ready_after", KW'(bus.key_ready), KW'(1));
    chk("err_after", KW'(err), KW'(exp_err));
    chk("done_count", KW'(n_done - d0), KW'(exp_done));
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got still running, want finished");
    $fatal(1);
  end

  initial begin
    vec_t          vt[4];
    logic [KW-1:0] cnt_key;
    logic [KW-1:0] rnd_key;
    int            d0;

    bus.key_valid = 1'b0;
    bus.key_data  = '0;
    bus.key_id    = 8'd0;
    for (int b = 0; b < KW / 8; b++) cnt_key[b*8 +: 8] = 8'(b);
    for (int w = 0; w < NW; w++) rnd_key[w*WW +: WW] = $urandom();

    vt[0] = '{cnt_key, 8'h05, 0, 2'b00, 1};
    vt[1] = '{cnt_key, 8'h05, 1, 2'b00, 1};
    vt[2] = '{{KW{1'b1}}, 8'hA5, 2, 2'b00, 1};
    vt[3] = '{rnd_key, 8'h3C, 0, 2'b00, 1};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_out_valid", KW'(bus.out_valid), KW'(0));
    chk("rst_out_data", KW'(bus.out_data), KW'(0));
    chk("rst_out_last", KW'(bus.out_last), KW'(0));
    chk("rst_out_key_id", KW'(bus.out_key_id), KW'(0));
    chk("rst_err", KW'(err), KW'(0));
    chk("rst_done", KW'(done), KW'(0));
    chk("rst_key_ready", KW'(bus.key_ready), KW'(1));
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_key_ready", KW'(bus.key_ready), KW'(1));

    for (int i = 0; i < 4; i++) begin
      run_key(vt[i].key, vt[i].id, vt[i].mode, vt[i].exp_err, vt[i].exp_done);
    end

    // Stall timeout with out_ready held low.
    rmode = 3;
    send_key(cnt_key, 8'h07);
    repeat (SMAX) @(negedge clk);
    chk("stall_valid_held", KW'(bus.out_valid), KW'(1));
    chk("stall_err_pending", KW'(err), KW'(0));
    @(negedge clk);
    chk("timeout_err", KW'(err), KW'(2'b01));
    chk("timeout_valid", KW'(bus.out_valid), KW'(0));
    chk("timeout_key_ready", KW'(bus.key_ready), KW'(0));
    exp_q.delete();
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("timeout_clr_err", KW'(err), KW'(0));
    chk("timeout_clr_ready", KW'(bus.key_ready), KW'(1));

    // Tamper while word 3 is presented.
    rmode = 0;
    d0 = n_done;
    send_key(cnt_key, 8'h09);
    repeat (3) @(negedge clk);
    @(posedge clk); #1 tamper_detect = 1'b1;
    @(negedge clk);
    chk("tamper_valid", KW'(bus.out_valid), KW'(0));
    chk("tamper_key_ready", KW'(bus.key_ready), KW'(0));
    @(posedge clk); #1 tamper_detect = 1'b0;
    @(negedge clk);
    chk("tamper_err", KW'(err), KW'(2'b10));
    chk("tamper_key_id", KW'(bus.out_key_id), KW'(0));
    chk("tamper_err_valid", KW'(bus.out_valid), KW'(0));
    exp_q.delete();
    @(posedge clk); #1 begin tamper_detect = 1'b1; err_clr = 1'b1; end
    @(posedge clk); #1 begin tamper_detect = 1'b0; err_clr = 1'b0; end
    @(negedge clk);
    chk("tamper_blocks_clr", KW'(err), KW'(2'b10));
    @(posedge clk); #1 err_clr = 1'b1;
    @(posedge clk); #1 err_clr = 1'b0;
    @(negedge clk);
    chk("tamper_clr_err", KW'(err), KW'(0));
    chk("tamper_clr_ready", KW'(bus.key_ready), KW'(1));
    chk("tamper_no_done", KW'(n_done - d0), KW'(0));

    // Reset mid-stream, then a fresh key must restart at word 0.
    d0 = n_done;
    send_key(cnt_key, 8'h11);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", KW'(bus.out_valid), KW'(0));
    chk("mid_rst_data", KW'(bus.out_data), KW'(0));
    chk("mid_rst_last", KW'(bus.out_last), KW'(0));
    chk("mid_rst_key_id", KW'(bus.out_key_id), KW'(0));
    chk("mid_rst_done", KW'(done), KW'(0));
    chk("mid_rst_ready", KW'(bus.key_ready), KW'(1));
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_no_done", KW'(n_done - d0), KW'(0));
    run_key(cnt_key, 8'h33, 0, 2'b00, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
